sd_spi: RTL and testbench
=========================

SD_SPI -- requirements
Module: sd_spi

Interface
REQ-001 SHALL have parameter HALF, default 2, meaning SCK half-period in fclk cycles (legal range 1..255).
REQ-002 SHALL have port fclk  input  1  sole clock, FPGA clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-fclk-cycle request to begin a byte exchange, already resynced to fclk upstream.
REQ-005 SHALL have port din  input  8  byte to transmit, sampled on the accepting edge only.
REQ-006 SHALL have port dout  output  8  last received byte, held until the next completion.
REQ-007 SHALL have port busy  output  1  high while an exchange is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse on completion.
REQ-009 SHALL have port sck  output  1  SPI clock to the SD card, idles low.
REQ-010 SHALL have port sdo  output  1  MOSI, idles high.
REQ-011 SHALL have port sdi  input  1  MISO from the SD card.

Function
REQ-012 SHALL implement SPI mode 0, MSB first, exactly 8 bits per exchange.
REQ-013 SHALL use two states: IDLE and XFER.
REQ-014 SHALL move IDLE->XFER on an edge E0 with start=1; on E0: busy<=1, shift register<=din, sdo<=din[7], sck stays 0, divider and bit counter cleared.
REQ-015 SHALL toggle sck every HALF fclk cycles in XFER: sck rises at E0+H, E0+3H, ... and falls at E0+2H, E0+4H, ... (H=HALF).
REQ-016 SHALL sample sdi into the shift register LSB on each edge that drives sck low, shifting left; on the same edge, sdo<=next bit, except after bit 0.
REQ-017 SHALL complete on edge E0+16H (8th falling sck): dout<=received byte, done=1 for exactly one cycle, sdo<=1, XFER->IDLE, busy<=0.
REQ-018 SHALL hold busy high for exactly 16*HALF cycles per exchange.
REQ-019 SHALL ignore start while busy=1 before the completion edge: no restart, no change to the shift register.
REQ-020 SHALL treat start=1 on the completion edge E0+16H as a back-to-back acceptance: completion actions per REQ-017 still occur, but the block stays in XFER, busy stays 1, the new din loads and sdo<=din[7]; sdo does not return high.
REQ-021 SHALL keep dout stable except on completion edges; it SHALL NOT reflect a partial shift.
REQ-022 SHALL use a divider counter of width ceil(log2(HALF+1)) with no wrap glitches; HALF=1 gives sck=fclk/2.

Reset
REQ-023 SHALL on rst_n=0, asynchronously and at any point including mid-exchange: state IDLE, busy=0, done=0, sck=0, sdo=1, dout=8'hFF, counters 0.
REQ-024 SHALL produce no sck edge and no done pulse for an exchange aborted by reset.
REQ-025 SHALL accept start on the first fclk edge after rst_n deasserts.

Structure
REQ-026 SHALL place the default HALF value, the bit count (8), the idle sdo level and the dout reset value (8'hFF) in a shared package or include.
REQ-027 SHALL, optionally, split the half-period tick generator into one sub-module, sd_spi_tick (enable in, tick out, cleared on accept); the shift/FSM logic stays in sd_spi.

Verification
REQ-028 SHALL check: HALF=2, sdi=sdo loopback, start with din=8'hA5 -> busy high exactly 32 cycles, 8 sck pulses, done pulse at E0+32, dout=8'hA5.
REQ-029 SHALL check: HALF=2, sdi tied 0, din=8'hFF -> dout=8'h00; sdo carries 1,1,1,1,1,1,1,1 then idles 1.
REQ-030 SHALL check: HALF=1, slave model returns 8'h3C -> dout=8'h3C, busy 16 cycles, sck period 2 fclk cycles.
REQ-031 SHALL check: start pulse with din=8'h00 at E0+10 during an exchange of 8'hA5 -> ignored; dout=8'hA5, single done pulse.
REQ-032 SHALL check: start with din=8'h81 on the completion edge of exchange 8'h5A (loopback) -> done pulses, dout=8'h5A, busy never drops, second done gives dout=8'h81.
REQ-033 SHALL check: rst_n asserted at E0+9 -> same cycle sck=0, sdo=1, busy=0, dout=8'hFF; no done pulse; a new start after release completes normally.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared constants and types for the SD-card SPI byte engine.
//   HalfDefault : default SCK half-period in fclk cycles
//   NumBits     : bits per exchange
//   SdoIdle     : MOSI level while idle
//   DoutRst     : received-byte value after reset
package sd_spi_pkg;

  localparam int unsigned HalfDefault = 2;
  localparam int unsigned NumBits     = 8;
  localparam logic        SdoIdle     = 1'b1;
  localparam logic [7:0]  DoutRst     = 8'hFF;

  typedef enum logic {
    StIdle,
    StXfer
  } state_e;

endpackage

// File: rtl/sd_spi_if.sv
// sd_spi_if: host handshake plus SPI pins of the SD-card SPI engine.
//   start/din      : request and byte to send (host -> engine)
//   dout/busy/done : received byte, activity flag, completion pulse (engine -> host)
//   sck/sdo        : SPI clock and MOSI (engine -> card)
//   sdi            : MISO (card -> engine)
interface sd_spi_if;
  import sd_spi_pkg::*;

  logic               start;
  logic [NumBits-1:0] din;
  logic [NumBits-1:0] dout;
  logic               busy;
  logic               done;
  logic               sck;
  logic               sdo;
  logic               sdi;

  modport slave (
    input  start, din, sdi,
    output dout, busy, done, sck, sdo
  );

  modport master (
    output start, din, sdi,
    input  dout, busy, done, sck, sdo
  );

endinterface

// File: rtl/sd_spi_tick.sv
// sd_spi_tick: half-period tick generator for SCK.
//   fclk, rst_n : clock, async active-low reset
//   en_i        : count while high (engine in XFER)
//   clr_i       : restart the half-period (exchange accepted)
//   tick_o      : high on the last fclk cycle of each half-period
module sd_spi_tick
  import sd_spi_pkg::*;
#(
  parameter int unsigned HALF = HalfDefault
) (
  input  logic fclk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned     CntW   = $clog2(HALF + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(HALF - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Explicit wrap at HALF-1 keeps the count inside its range for every HALF.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == CntMax);

endmodule

// File: rtl/sd_spi.sv
// sd_spi: SPI mode-0, MSB-first, 8-bit exchange engine for an SD card.
//   fclk   : sole clock
//   rst_n  : async active-low reset
//   spi_io : host handshake (start/din/dout/busy/done) and SPI pins (sck/sdo/sdi)
//   HALF   : SCK half-period in fclk cycles (1..255)
module sd_spi
  import sd_spi_pkg::*;
#(
  parameter int unsigned HALF = HalfDefault
) (
  input logic     fclk,
  input logic     rst_n,
  sd_spi_if.slave spi_io
);

  state_e             state_q;
  logic [NumBits-1:0] shreg_q;
  logic [NumBits-1:0] dout_q;
  logic [2:0]         bit_q;
  logic               busy_q, done_q, sck_q, sdo_q;
  logic               tick, xfer, last_fall, accept;

  assign xfer      = (state_q == StXfer);
  // The eighth falling SCK edge completes the exchange.
  assign last_fall = xfer && tick && sck_q && (bit_q == 3'(NumBits - 1));
  // A start landing exactly on the completion edge chains the next byte.
  assign accept    = spi_io.start && (!xfer || last_fall);

  sd_spi_tick #(
    .HALF (HALF)
  ) u_tick (
    .fclk   (fclk),
    .rst_n  (rst_n),
    .en_i   (xfer),
    .clr_i  (accept),
    .tick_o (tick)
  );

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shreg_q <= '0;
      dout_q  <= DoutRst;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sck_q   <= 1'b0;
      sdo_q   <= SdoIdle;
    end else begin
      done_q <= 1'b0;
      if (last_fall) begin
        dout_q  <= {shreg_q[NumBits-2:0], spi_io.sdi};
        done_q  <= 1'b1;
        sck_q   <= 1'b0;
        sdo_q   <= SdoIdle;
        busy_q  <= 1'b0;
        state_q <= StIdle;
      end else if (xfer && tick) begin
        sck_q <= ~sck_q;
        if (sck_q) begin
          // Falling SCK: capture MISO, present the next MOSI bit.
          shreg_q <= {shreg_q[NumBits-2:0], spi_io.sdi};
          sdo_q   <= shreg_q[NumBits-2];
          bit_q   <= bit_q + 3'd1;
        end
      end
      // Later assignments win, so a chained accept overrides the return to idle.
      if (accept) begin
        state_q <= StXfer;
        busy_q  <= 1'b1;
        shreg_q <= spi_io.din;
        sdo_q   <= spi_io.din[NumBits-1];
        sck_q   <= 1'b0;
        bit_q   <= '0;
      end
    end
  end

  assign spi_io.dout = dout_q;
  assign spi_io.busy = busy_q;
  assign spi_io.done = done_q;
  assign spi_io.sck  = sck_q;
  assign spi_io.sdo  = sdo_q;

endmodule

// File: tb/tb_sd_spi.sv
// tb_sd_spi: two engines (HALF=2 and HALF=1) share start/din; each has its own card model,
// transaction-level reference and done-driven scoreboard.
module tb_sd_spi;

  logic       fclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] din = 8'h00;
  int         mode = 1;          // 0 random, 1 loopback, 2 fixed card response
  logic [7:0] fixed_resp = 8'h00;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 fclk = ~fclk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned H = (g == 0) ? 2 : 1;

    sd_spi_if bus ();

    sd_spi #(
      .HALF (H)
    ) u_dut (
      .fclk   (fclk),
      .rst_n  (rst_n),
      .spi_io (bus)
    );

    logic sdi_q = 1'b1;
    assign bus.start = start;
    assign bus.din   = din;
    assign bus.sdi   = sdi_q;

    // Reference: t counts fclk edges since acceptance; an exchange lasts 16*H edges.
    bit         m_busy = 0;
    bit         m_done = 0;
    bit         m_loop = 0;
    bit         acc;
    int         m_t = 0;
    logic [7:0] m_tx = 8'h00;
    logic [7:0] m_resp = 8'h00;
    logic [7:0] m_rx = 8'h00;
    logic [7:0] m_dout = 8'hFF;
    logic [7:0] exp_q[$];

    initial forever begin
      @(posedge fclk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 0;
        m_done = 0;
        m_t    = 0;
        m_dout = 8'hFF;
        exp_q.delete();
      end else begin
        m_done = 0;
        acc    = 0;
        if (!m_busy) begin
          acc = start;
        end else begin
          m_t++;
          if (m_t == 16 * H) begin
            m_done = 1;
            m_dout = m_rx;
            m_busy = 0;
            acc    = start;
          end
        end
        if (acc) begin
          m_busy = 1;
          m_t    = 0;
          m_tx   = din;
          m_loop = (mode == 1) || (mode == 0 && $urandom_range(0, 1) == 1);
          m_resp = (mode == 2) ? fixed_resp : 8'($urandom);
          m_rx   = m_loop ? m_tx : m_resp;
          exp_q.push_back(m_rx);
        end
      end
    end

    // Monitor: pin-level comparison every cycle, scoreboard pop on done.
    int         idx;
    int         rises = 0;
    logic       sck_prev = 1'b0;
    logic       exp_sck, exp_sdo;
    logic [7:0] popped;

    initial forever begin
      @(negedge fclk);
      idx     = m_busy ? m_t / (2 * H) : 0;
      exp_sck = m_busy && ((m_t / H) % 2 == 1);
      exp_sdo = m_busy ? m_tx[7 - idx] : 1'b1;
      check($sformatf("h%0d busy/done/sck/sdo t=%0d", H, m_t),
            {28'd0, bus.busy, bus.done, bus.sck, bus.sdo},
            {28'd0, m_busy, m_done, exp_sck, exp_sdo});
      check($sformatf("h%0d dout hold", H), {24'd0, bus.dout}, {24'd0, m_dout});
      if (!rst_n) rises = 0;
      else if (bus.sck === 1'b1 && sck_prev === 1'b0) rises++;
      sck_prev = bus.sck;
      if (bus.done === 1'b1) begin
        check($sformatf("h%0d sck rises per byte", H), rises, 8);
        rises = 0;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL h%0d done: got pulse with dout %0h, expected no pulse", H, bus.dout);
        end else begin
          popped = exp_q.pop_front();
          check($sformatf("h%0d done dout", H), {24'd0, bus.dout}, {24'd0, popped});
        end
      end
      // Card side: loopback echoes MOSI, otherwise shift out the response MSB first.
      if (!m_busy) sdi_q = 1'b1;
      else if (m_loop) sdi_q = bus.sdo;
      else sdi_q = m_resp[7 - idx];
    end
  end

  task automatic pulse(input logic [7:0] d);
    start = 1'b1;
    din   = d;
    @(negedge fclk);
    start = 1'b0;
    din   = 8'($urandom);
  endtask

  initial begin
    repeat (3) @(negedge fclk);
    check("reset h2", {g_dut[0].bus.busy, g_dut[0].bus.sck, g_dut[0].bus.sdo,
                       g_dut[0].bus.done, g_dut[0].bus.dout}, {4'b0010, 8'hFF});
    check("reset h1", {g_dut[1].bus.busy, g_dut[1].bus.sck, g_dut[1].bus.sdo,
                       g_dut[1].bus.done, g_dut[1].bus.dout}, {4'b0010, 8'hFF});
    rst_n = 1'b1;
    // Loopback A5, start on the first edge after reset release.
    mode = 1;
    pulse(8'hA5);
    repeat (40) @(negedge fclk);
    // Card holds MISO low, all-ones transmitted.
    mode = 2;
    fixed_resp = 8'h00;
    pulse(8'hFF);
    repeat (40) @(negedge fclk);
    // Card returns 3C.
    fixed_resp = 8'h3C;
    pulse(8'h96);
    repeat (40) @(negedge fclk);
    // Start at E0+10 while busy is ignored.
    mode = 1;
    pulse(8'hA5);
    repeat (9) @(negedge fclk);
    pulse(8'h00);
    repeat (40) @(negedge fclk);
    // Start on the HALF=2 completion edge chains 81 behind 5A.
    pulse(8'h5A);
    repeat (31) @(negedge fclk);
    pulse(8'h81);
    repeat (40) @(negedge fclk);
    // Reset at E0+9, checked within the same cycle.
    pulse(8'hC3);
    repeat (8) @(negedge fclk);
    @(posedge fclk);
    #1 rst_n = 1'b0;
    #1;
    check("mid reset h2", {g_dut[0].bus.busy, g_dut[0].bus.sck, g_dut[0].bus.sdo,
                           g_dut[0].bus.done, g_dut[0].bus.dout}, {4'b0010, 8'hFF});
    check("mid reset h1", {g_dut[1].bus.busy, g_dut[1].bus.sck, g_dut[1].bus.sdo,
                           g_dut[1].bus.done, g_dut[1].bus.dout}, {4'b0010, 8'hFF});
    repeat (2) @(negedge fclk);
    rst_n = 1'b1;
    pulse(8'h3E);
    repeat (40) @(negedge fclk);
    // Random traffic, including starts while busy and on completion edges.
    mode = 0;
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 9) == 0);
      din   = 8'($urandom);
      @(negedge fclk);
    end
    start = 1'b0;
    repeat (40) @(negedge fclk);
    check("h2 scoreboard drained", g_dut[0].exp_q.size(), 0);
    check("h1 scoreboard drained", g_dut[1].exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
